// File: rtl/bnb_pkg.sv
// bnb_pkg: shared reset value and default geometry for the shift-pair demo
package bnb_pkg;
  localparam logic BNB_RST_VAL = 1'b0;
  localparam int BNB_WIDTH = 1;
  localparam int BNB_DEPTH = 2;
endpackage

// File: rtl/bnb_dff.sv
// bnb_dff: WIDTH-bit D flop with synchronous active-high reset
module bnb_dff
  import bnb_pkg::*;
#(
  parameter int WIDTH = BNB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_d, q_q;
  always_comb q_d = rst ? {WIDTH{BNB_RST_VAL}} : d;
  always_ff @(posedge clk) q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/bnb_shift_pair.sv
// bnb_shift_pair: blocking-style chain (collapses to 1 flop) beside a true DEPTH-stage shift register
module bnb_shift_pair
  import bnb_pkg::*;
#(
  parameter int WIDTH = BNB_WIDTH,
  parameter int DEPTH = BNB_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_blk,
  output logic [WIDTH-1:0] q_nblk
);
  logic [WIDTH-1:0] stage [DEPTH];
  logic [WIDTH-1:0] blk_d, blk_q;
  // Blocking chain: each stage sees the freshly written one, so only the tail needs a flop.
  always_comb begin
    stage[0] = d;
    for (int i = 1; i < DEPTH; i++) stage[i] = stage[i-1];
    blk_d = rst ? {WIDTH{BNB_RST_VAL}} : stage[DEPTH-1];
  end
  always_ff @(posedge clk) blk_q <= blk_d;
  assign q_blk = blk_q;
  logic [DEPTH:0][WIDTH-1:0] chain;
  assign chain[0] = d;
  for (genvar g = 0; g < DEPTH; g++) begin : g_nblk
    bnb_dff #(.WIDTH(WIDTH)) u_dff (
      .clk(clk),
      .rst(rst),
      .d  (chain[g]),
      .q  (chain[g+1])
    );
  end
  assign q_nblk = chain[DEPTH];
endmodule

// File: tb/tb_bnb_shift_pair.sv
// tb_bnb_shift_pair: directed checks of both chains at default and swept geometries
module tb_bnb_shift_pair;
  logic clk = 1'b0;
  logic rst;
  logic d_a;
  logic qb_a, qn_a;
  logic [7:0] d8, qb_b, qn_b, qb_c, qn_c;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  bnb_shift_pair u_a (.clk(clk), .rst(rst), .d(d_a), .q_blk(qb_a), .q_nblk(qn_a));
  bnb_shift_pair #(.WIDTH(8), .DEPTH(1)) u_b (.clk(clk), .rst(rst), .d(d8), .q_blk(qb_b), .q_nblk(qn_b));
  bnb_shift_pair #(.WIDTH(8), .DEPTH(4)) u_c (.clk(clk), .rst(rst), .d(d8), .q_blk(qb_c), .q_nblk(qn_c));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_a(input string tag, input logic eb, input logic en);
    chk({tag, " q_blk"}, {7'd0, qb_a}, {7'd0, eb});
    chk({tag, " q_nblk"}, {7'd0, qn_a}, {7'd0, en});
  endtask
  initial begin
    logic s [15] = '{0,0,0,1,0,0,0,1,1,1,1,0,0,1,1};
    logic [7:0] h [20];
    rst = 1'b1; d_a = 1'b1; d8 = 8'hff;
    tick(); tick();
    chk_a("reset", 1'b0, 1'b0);
    chk("reset b blk", qb_b, 8'h00);
    chk("reset b nblk", qn_b, 8'h00);
    chk("reset c blk", qb_c, 8'h00);
    chk("reset c nblk", qn_c, 8'h00);
    rst = 1'b0; d_a = 1'b0;
    tick(); chk_a("release0", 1'b0, 1'b0);
    tick(); chk_a("release1", 1'b0, 1'b0);
    d_a = 1'b1; tick(); chk_a("pulse0", 1'b1, 1'b0);
    d_a = 1'b0; tick(); chk_a("pulse1", 1'b0, 1'b1);
    tick(); chk_a("pulse2", 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      d_a = s[i];
      tick();
      chk_a($sformatf("stream%0d", i), s[i], (i > 0) ? s[i-1] : 1'b0);
    end
    d_a = 1'b0; tick(); chk_a("pre_glitch", 1'b0, 1'b1);
    #2 d_a = 1'b1;
    #2 d_a = 1'b0;
    chk_a("glitch_hold", 1'b0, 1'b1);
    tick(); chk_a("glitch_edge", 1'b0, 1'b0);
    d_a = 1'b1;
    tick(); tick(); tick(); chk_a("ones", 1'b1, 1'b1);
    rst = 1'b1; tick(); chk_a("mid_rst", 1'b0, 1'b0);
    rst = 1'b0; d_a = 1'b1;
    tick(); chk_a("resume0", 1'b1, 1'b0);
    tick(); chk_a("resume1", 1'b1, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      h[k] = 8'($urandom_range(0, 255));
      d8 = h[k];
      tick();
      chk($sformatf("sweep%0d b blk", k), qb_b, h[k]);
      chk($sformatf("sweep%0d b nblk", k), qn_b, h[k]);
      chk($sformatf("sweep%0d b eq", k), qn_b, qb_b);
      chk($sformatf("sweep%0d c blk", k), qb_c, h[k]);
      chk($sformatf("sweep%0d c nblk", k), qn_c, (k >= 3) ? h[k-3] : 8'h00);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
